motor_ramp_ctrl: RTL and testbench

Two-channel speed/direction sequencer placed between the switch/command inputs and the PWM generators for motors A and B. It slews each channel's PWM duty toward its commanded speed one step per ramp tick. A direction reversal always ramps to zero duty, brakes for a dwell period, and only then drives the new direction. An emergency-stop input overrides both channels.

---
 rtl/motor_ramp_ctrl_pkg.sv | 20 ++
 rtl/motor_ramp_ctrl_if.sv | 38 +++
 rtl/motor_ramp_ctrl_channel.sv | 156 +++++++++++++++
 rtl/motor_ramp_ctrl.sv | 88 ++++++++
 tb/tb_motor_ramp_ctrl.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/motor_ramp_ctrl_pkg.sv
// Shared H-bridge direction codes and per-channel sequencer states for motor_ramp_ctrl.
package motor_ctrl_pkg;

  localparam logic [1:0] DIR_COAST = 2'b00;
  localparam logic [1:0] DIR_FWD   = 2'b10;
  localparam logic [1:0] DIR_REV   = 2'b01;
  localparam logic [1:0] DIR_BRAKE = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD,
    DWELL
  } ch_state_e;

  function automatic logic [1:0] dir_of(input logic rev);
    return rev ? DIR_REV : DIR_FWD;
  endfunction

endpackage

// File: rtl/motor_ramp_ctrl_if.sv
// Command/status bundle between the command source and motor_ramp_ctrl.
// The led field exists only when MOTOR_STATUS_LED_EN is defined.
interface motor_ramp_ctrl_if #(
  parameter int unsigned DUTY_W = 4
);

  logic [DUTY_W-1:0] cmd_spd_a;
  logic              cmd_rev_a;
  logic [DUTY_W-1:0] cmd_spd_b;
  logic              cmd_rev_b;
  logic              estop;
  logic [DUTY_W-1:0] duty_a;
  logic [1:0]        dir_a;
  logic [DUTY_W-1:0] duty_b;
  logic [1:0]        dir_b;
  logic              busy_a;
  logic              busy_b;
`ifdef MOTOR_STATUS_LED_EN
  logic [7:0]        led;
`endif

  modport master (
    output cmd_spd_a, cmd_rev_a, cmd_spd_b, cmd_rev_b, estop,
    input  duty_a, dir_a, duty_b, dir_b, busy_a, busy_b
`ifdef MOTOR_STATUS_LED_EN
    , input led
`endif
  );

  modport slave (
    input  cmd_spd_a, cmd_rev_a, cmd_spd_b, cmd_rev_b, estop,
    output duty_a, dir_a, duty_b, dir_b, busy_a, busy_b
`ifdef MOTOR_STATUS_LED_EN
    , output led
`endif
  );

endinterface

// File: rtl/motor_ramp_ctrl_channel.sv
// One motor channel: duty ramp, direction sequencing with brake dwell, estop override.
// MOTOR_STATUS_LED_EN adds a registered status nibble (duty, or 4'hF while dwelling).
module ramp_channel
  import motor_ctrl_pkg::*;
#(
  parameter int unsigned DUTY_W       = 4,
  parameter int unsigned DWELL_CYCLES = 5000000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tick_i,
  input  logic              estop_i,
  input  logic [DUTY_W-1:0] cmd_spd_i,
  input  logic              cmd_rev_i,
  output logic [DUTY_W-1:0] duty_o,
  output logic [1:0]        dir_o,
  output logic              busy_o
`ifdef MOTOR_STATUS_LED_EN
  ,
  output logic [3:0]        led_nib_o
`endif
);

  localparam int unsigned       CntW      = $clog2(DWELL_CYCLES + 1);
  localparam logic [CntW-1:0]   DwellLoad = CntW'(DWELL_CYCLES);
  localparam logic [DUTY_W-1:0] DutyMax   = '1;

  ch_state_e         state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [1:0]        dir_q, dir_d;
  logic              busy_q, busy_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [1:0]        tgt_dir;
  logic              match;
  logic [DUTY_W-1:0] step_duty;

  always_comb begin
    tgt_dir   = dir_of(cmd_rev_i);
    match     = (dir_q == tgt_dir);
    step_duty = duty_q;
    // A direction mismatch always ramps down; duty never wraps at either end.
    if (match && (cmd_spd_i > duty_q) && (duty_q != DutyMax)) begin
      step_duty = duty_q + 1'b1;
    end else if ((!match || (cmd_spd_i < duty_q)) && (duty_q != '0)) begin
      step_duty = duty_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;

    if (estop_i) begin
      state_d = DWELL;
      duty_d  = '0;
      dir_d   = DIR_BRAKE;
      busy_d  = 1'b1;
      cnt_d   = DwellLoad;
    end else begin
      unique case (state_q)
        IDLE: begin
          duty_d = '0;
          dir_d  = DIR_COAST;
          busy_d = 1'b0;
          if (cmd_spd_i != '0) begin
            dir_d   = tgt_dir;
            state_d = RUN;
            busy_d  = 1'b1;
          end
        end
        RUN: begin
          if (tick_i) begin
            duty_d = step_duty;
          end
          // Settling is judged on the post-step duty so exits happen on the step edge.
          if ((duty_d == '0) && (cmd_spd_i == '0)) begin
            state_d = IDLE;
            dir_d   = DIR_COAST;
            busy_d  = 1'b0;
          end else if ((duty_d == '0) && !match) begin
            state_d = DWELL;
            dir_d   = DIR_BRAKE;
            cnt_d   = DwellLoad;
          end else if (match && (duty_d == cmd_spd_i)) begin
            state_d = HOLD;
            busy_d  = 1'b0;
          end
        end
        HOLD: begin
          if ((cmd_spd_i != duty_q) || !match) begin
            state_d = RUN;
            busy_d  = 1'b1;
          end
        end
        DWELL: begin
          duty_d = '0;
          dir_d  = DIR_BRAKE;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q <= CntW'(1)) begin
            cnt_d = '0;
            if (cmd_spd_i != '0) begin
              dir_d   = tgt_dir;
              state_d = RUN;
            end else begin
              dir_d   = DIR_COAST;
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      duty_q  <= '0;
      dir_q   <= DIR_COAST;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign duty_o = duty_q;
  assign dir_o  = dir_q;
  assign busy_o = busy_q;

`ifdef MOTOR_STATUS_LED_EN
  logic [3:0] led_nib_q, led_nib_d;

  assign led_nib_d = (state_d == DWELL) ? 4'hF : 4'(duty_d);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      led_nib_q <= 4'h0;
    end else begin
      led_nib_q <= led_nib_d;
    end
  end

  assign led_nib_o = led_nib_q;
`endif

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Two-channel motor speed/direction sequencer: shared ramp prescaler plus two ramp_channel FSMs.
// Define MOTOR_STATUS_LED_EN to drive the led status byte on the interface.
module motor_ramp_ctrl
  import motor_ctrl_pkg::*;
#(
  parameter int unsigned RAMP_STEP_CYCLES = 1000000,
  parameter int unsigned DWELL_CYCLES     = 5000000,
  parameter int unsigned DUTY_W           = 4
) (
  input logic               clk,
  input logic               res,
  motor_ramp_ctrl_if.slave  bus
);

  localparam int unsigned     PreW   = $clog2(RAMP_STEP_CYCLES);
  localparam logic [PreW-1:0] PreMax = PreW'(RAMP_STEP_CYCLES - 1);

  logic [PreW-1:0] pre_q, pre_d;
  logic            tick;

  // Tick is high in the last cycle of each period so the step lands on the period boundary.
  assign tick  = (pre_q == PreMax);
  assign pre_d = tick ? '0 : pre_q + 1'b1;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  logic [DUTY_W-1:0] duty_a, duty_b;
  logic [1:0]        dir_a, dir_b;
  logic              busy_a, busy_b;
`ifdef MOTOR_STATUS_LED_EN
  logic [3:0]        nib_a, nib_b;
`endif

  ramp_channel #(
    .DUTY_W       (DUTY_W),
    .DWELL_CYCLES (DWELL_CYCLES)
  ) u_chan_a (
    .clk_i     (clk),
    .rst_ni    (res),
    .tick_i    (tick),
    .estop_i   (bus.estop),
    .cmd_spd_i (bus.cmd_spd_a),
    .cmd_rev_i (bus.cmd_rev_a),
    .duty_o    (duty_a),
    .dir_o     (dir_a),
    .busy_o    (busy_a)
`ifdef MOTOR_STATUS_LED_EN
    ,
    .led_nib_o (nib_a)
`endif
  );

  ramp_channel #(
    .DUTY_W       (DUTY_W),
    .DWELL_CYCLES (DWELL_CYCLES)
  ) u_chan_b (
    .clk_i     (clk),
    .rst_ni    (res),
    .tick_i    (tick),
    .estop_i   (bus.estop),
    .cmd_spd_i (bus.cmd_spd_b),
    .cmd_rev_i (bus.cmd_rev_b),
    .duty_o    (duty_b),
    .dir_o     (dir_b),
    .busy_o    (busy_b)
`ifdef MOTOR_STATUS_LED_EN
    ,
    .led_nib_o (nib_b)
`endif
  );

  assign bus.duty_a = duty_a;
  assign bus.dir_a  = dir_a;
  assign bus.busy_a = busy_a;
  assign bus.duty_b = duty_b;
  assign bus.dir_b  = dir_b;
  assign bus.busy_b = busy_b;
`ifdef MOTOR_STATUS_LED_EN
  assign bus.led    = {nib_b, nib_a};
`endif

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl with RAMP_STEP_CYCLES = 4 and DWELL_CYCLES = 8.
module tb_motor_ramp_ctrl;

  localparam int unsigned DutyW = 4;
  localparam int unsigned Ramp  = 4;
  localparam int unsigned Dwell = 8;

  logic clk = 1'b0;
  logic res = 1'b1;
  int   checks = 0;
  int   passes = 0;

  motor_ramp_ctrl_if #(.DUTY_W(DutyW)) bus ();

  motor_ramp_ctrl #(
    .RAMP_STEP_CYCLES (Ramp),
    .DWELL_CYCLES     (Dwell),
    .DUTY_W           (DutyW)
  ) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until duty changes from prev; n is the number of clocks taken (16 = gave up).
  task automatic wait_duty_a(input logic [DutyW-1:0] prev, output int n);
    n = 0;
    while (bus.duty_a === prev && n < 16) begin
      step();
      n++;
    end
  endtask

  task automatic wait_duty_b(input logic [DutyW-1:0] prev, output int n);
    n = 0;
    while (bus.duty_b === prev && n < 16) begin
      step();
      n++;
    end
  endtask

  task automatic count_brake_a(output int n);
    n = 0;
    while (bus.dir_a === 2'b11 && n < 32) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    bus.cmd_spd_a = '0;
    bus.cmd_rev_a = 1'b0;
    bus.cmd_spd_b = '0;
    bus.cmd_rev_b = 1'b0;
    bus.estop     = 1'b0;
    #1 res = 1'b0;
    #12;
    checks++;
    if (bus.duty_a !== 4'd0 || bus.dir_a !== 2'b00 || bus.busy_a !== 1'b0)
      $display("FAIL reset_a: duty=%0d dir=%b busy=%b required 0 00 0",
               bus.duty_a, bus.dir_a, bus.busy_a);
    else passes++;
    checks++;
    if (bus.duty_b !== 4'd0 || bus.dir_b !== 2'b00 || bus.busy_b !== 1'b0)
      $display("FAIL reset_b: duty=%0d dir=%b busy=%b required 0 00 0",
               bus.duty_b, bus.dir_b, bus.busy_b);
    else passes++;
    step();
    res = 1'b1;
  endtask

  task automatic test_ramp_up();
    int n;
    bus.cmd_spd_a = 4'd5;
    bus.cmd_rev_a = 1'b0;
    step();
    checks++;
    if (bus.dir_a !== 2'b10 || bus.busy_a !== 1'b1)
      $display("FAIL up_start: dir=%b busy=%b required 10 1", bus.dir_a, bus.busy_a);
    else passes++;
    for (int v = 1; v <= 5; v++) begin
      wait_duty_a(bus.duty_a, n);
      checks++;
      if (bus.duty_a !== 4'(v)) $display("FAIL up_duty: duty=%0d required %0d", bus.duty_a, v);
      else passes++;
      if (v > 1) begin
        checks++;
        if (n != 4) $display("FAIL up_interval: %0d clocks required 4", n);
        else passes++;
      end
    end
    checks++;
    if (bus.busy_a !== 1'b0 || bus.dir_a !== 2'b10)
      $display("FAIL up_settle: busy=%b dir=%b required 0 10", bus.busy_a, bus.dir_a);
    else passes++;
  endtask

  task automatic test_reversal();
    int n;
    bus.cmd_rev_a = 1'b1;
    step();
    checks++;
    if (bus.busy_a !== 1'b1) $display("FAIL rev_busy: busy=%b required 1", bus.busy_a);
    else passes++;
    for (int v = 4; v >= 0; v--) begin
      wait_duty_a(bus.duty_a, n);
      checks++;
      if (bus.duty_a !== 4'(v)) $display("FAIL rev_down: duty=%0d required %0d", bus.duty_a, v);
      else passes++;
      if (v < 4) begin
        checks++;
        if (n != 4) $display("FAIL rev_interval: %0d clocks required 4", n);
        else passes++;
      end
    end
    checks++;
    if (bus.dir_a !== 2'b11) $display("FAIL rev_brake: dir=%b required 11", bus.dir_a);
    else passes++;
    count_brake_a(n);
    checks++;
    if (n != 8) $display("FAIL rev_dwell_len: %0d cycles required 8", n);
    else passes++;
    checks++;
    if (bus.dir_a !== 2'b01 || bus.duty_a !== 4'd0)
      $display("FAIL rev_new_dir: dir=%b duty=%0d required 01 0", bus.dir_a, bus.duty_a);
    else passes++;
    for (int v = 1; v <= 5; v++) begin
      wait_duty_a(bus.duty_a, n);
      checks++;
      if (bus.duty_a !== 4'(v)) $display("FAIL rev_up: duty=%0d required %0d", bus.duty_a, v);
      else passes++;
    end
    checks++;
    if (bus.busy_a !== 1'b0) $display("FAIL rev_settle: busy=%b required 0", bus.busy_a);
    else passes++;
  endtask

  task automatic test_channel_b();
    int n;
    bus.cmd_spd_b = 4'd3;
    bus.cmd_rev_b = 1'b0;
    step();
    checks++;
    if (bus.dir_b !== 2'b10) $display("FAIL b_dir: dir_b=%b required 10", bus.dir_b);
    else passes++;
    for (int v = 1; v <= 3; v++) begin
      wait_duty_b(bus.duty_b, n);
      checks++;
      if (bus.duty_b !== 4'(v)) $display("FAIL b_up: duty_b=%0d required %0d", bus.duty_b, v);
      else passes++;
    end
    checks++;
    if (bus.busy_b !== 1'b0) $display("FAIL b_settle: busy_b=%b required 0", bus.busy_b);
    else passes++;
    bus.cmd_spd_b = 4'd0;
    step();
    checks++;
    if (bus.busy_b !== 1'b1) $display("FAIL b_rerun: busy_b=%b required 1", bus.busy_b);
    else passes++;
    for (int v = 2; v >= 0; v--) begin
      wait_duty_b(bus.duty_b, n);
      checks++;
      if (bus.duty_b !== 4'(v)) $display("FAIL b_down: duty_b=%0d required %0d", bus.duty_b, v);
      else passes++;
    end
    checks++;
    if (bus.dir_b !== 2'b00 || bus.busy_b !== 1'b0)
      $display("FAIL b_idle: dir_b=%b busy_b=%b required 00 0", bus.dir_b, bus.busy_b);
    else passes++;
    checks++;
    if (bus.duty_a !== 4'd5 || bus.dir_a !== 2'b01 || bus.busy_a !== 1'b0)
      $display("FAIL b_isolation: duty_a=%0d dir_a=%b busy_a=%b required 5 01 0",
               bus.duty_a, bus.dir_a, bus.busy_a);
    else passes++;
  endtask

  task automatic test_estop();
    int n;
    bus.estop = 1'b1;
    step();
    checks++;
    if (bus.duty_a !== 4'd0 || bus.dir_a !== 2'b11 || bus.busy_a !== 1'b1)
      $display("FAIL estop_hit: duty=%0d dir=%b busy=%b required 0 11 1",
               bus.duty_a, bus.dir_a, bus.busy_a);
    else passes++;
    checks++;
    if (bus.dir_b !== 2'b11) $display("FAIL estop_b: dir_b=%b required 11", bus.dir_b);
    else passes++;
    repeat (19) step();
    checks++;
    if (bus.dir_a !== 2'b11) $display("FAIL estop_held: dir=%b required 11", bus.dir_a);
    else passes++;
    bus.estop = 1'b0;
    count_brake_a(n);
    checks++;
    if (n != 8) $display("FAIL estop_dwell_len: %0d cycles required 8", n);
    else passes++;
    checks++;
    if (bus.dir_a !== 2'b01 || bus.dir_b !== 2'b00)
      $display("FAIL estop_resume: dir_a=%b dir_b=%b required 01 00", bus.dir_a, bus.dir_b);
    else passes++;
    for (int v = 1; v <= 5; v++) begin
      wait_duty_a(bus.duty_a, n);
      checks++;
      if (bus.duty_a !== 4'(v)) $display("FAIL estop_ramp: duty=%0d required %0d", bus.duty_a, v);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_ramp();
    int n;
    bus.cmd_spd_a = 4'd0;
    wait_duty_a(bus.duty_a, n);
    wait_duty_a(bus.duty_a, n);
    checks++;
    if (bus.duty_a !== 4'd3) $display("FAIL midreset_pre: duty=%0d required 3", bus.duty_a);
    else passes++;
    #2 res = 1'b0;
    #1;
    checks++;
    if (bus.duty_a !== 4'd0 || bus.dir_a !== 2'b00 || bus.busy_a !== 1'b0)
      $display("FAIL midreset_async: duty=%0d dir=%b busy=%b required 0 00 0",
               bus.duty_a, bus.dir_a, bus.busy_a);
    else passes++;
    #2;
    bus.cmd_spd_a = 4'd15;
    bus.cmd_rev_a = 1'b0;
    res = 1'b1;
  endtask

  task automatic test_saturate();
    int n;
    step();
    checks++;
    if (bus.dir_a !== 2'b10) $display("FAIL sat_dir: dir=%b required 10", bus.dir_a);
    else passes++;
    wait_duty_a(bus.duty_a, n);
    checks++;
    if (n != 3 || bus.duty_a !== 4'd1)
      $display("FAIL sat_first_tick: %0d clocks duty=%0d required 3 clocks duty 1", n, bus.duty_a);
    else passes++;
    for (int v = 2; v <= 15; v++) begin
      wait_duty_a(bus.duty_a, n);
      checks++;
      if (bus.duty_a !== 4'(v) || n != 4)
        $display("FAIL sat_up: duty=%0d after %0d clocks required %0d after 4", bus.duty_a, n, v);
      else passes++;
    end
    checks++;
    if (bus.busy_a !== 1'b0) $display("FAIL sat_settle: busy=%b required 0", bus.busy_a);
    else passes++;
    repeat (12) step();
    checks++;
    if (bus.duty_a !== 4'd15) $display("FAIL sat_hold: duty=%0d required 15", bus.duty_a);
    else passes++;
`ifdef MOTOR_STATUS_LED_EN
    checks++;
    if (bus.led[3:0] !== 4'hF) $display("FAIL sat_led: led[3:0]=%h required f", bus.led[3:0]);
    else passes++;
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ramp_up();
    test_reversal();
    test_channel_b();
    test_estop();
    test_reset_mid_ramp();
    test_saturate();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
